pkt_merger: RTL and testbench
=============================

# pkt_merger

Egress merge point that recombines the data-path stream leaving the match-action pipeline with control-path responses onto a single AXI-Stream toward the MAC/DMA. The control input has no back-pressure, so control beats are staged in an internal packet FIFO with drop-on-overflow. Arbitration is packet-atomic, so beats of two packets are never interleaved. Output is fully registered.

## Interface
- C_S_AXIS_DATA_WIDTH, 512, tdata width; tkeep is width/8
- C_S_AXIS_TUSER_WIDTH, 128, tuser width
- C_FIFO_DEPTH_LOG2, 4, control FIFO depth = 2**C_FIFO_DEPTH_LOG2 beats
- clk  in  1  single clock
- aresetn  in  1  reset; synchronous, active-low
- s_axis_tdata/tkeep/tuser/tvalid/tlast  in  per params  data-path input
- s_axis_tready  out  1  data-path ready (combinational)
- c_s_axis_tdata/tkeep/tuser/tvalid/tlast  in  per params  control-path input, no ready
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  per params  merged output, registered
- m_axis_tready  in  1  downstream ready
- c_drop_cnt  out  32  control packets dropped, saturating at 32'hFFFF_FFFF

## Operation
- Control FIFO write side, each cycle with c_s_axis_tvalid=1:
  - drop flag set: discard beat; clear flag if tlast.
  - FIFO full, i.e. wr_ptr-rd_ptr == depth from registered pointers: rewind wr_ptr to wr_commit; c_drop_cnt+1; set drop flag unless beat is tlast.
  - otherwise: write beat, wr_ptr+1; on tlast, wr_commit=wr_ptr+1 and pkt_cnt+1.
- Pointers are C_FIFO_DEPTH_LOG2+1 bits and wrap naturally. A packet longer than depth is always dropped.
- pkt_cnt counts complete packets. It increments on commit and decrements when the tlast beat is read; both in one cycle leaves it unchanged. ctrl_pend = (pkt_cnt != 0).
- Only committed packets are readable, so a control packet always streams without bubbles.
- FSM:
  - IDLE -> CTRL if ctrl_pend, else -> DATA if s_axis_tvalid. Decision is made in IDLE; no beat moves that cycle.
  - DATA: s_axis_tready = (m_axis_tready | ~m_axis_tvalid). Each accepted beat loads the output register. The accepted tlast beat -> IDLE.
  - CTRL: FIFO head loads the output register under the same advance condition. The tlast beat read -> IDLE.
- Priority on contention in IDLE: control wins (strict), unless PKT_MERGER_RR_EN is defined.
- Output register advances when m_axis_tready | ~m_axis_tvalid. When not loading a new beat and the current beat is consumed, m_axis_tvalid goes to 0.
- s_axis_tready is 0 in IDLE and CTRL.

## Timing
- Reset (aresetn=0 at clk edge):
  - state=IDLE.
  - All m_axis_* = 0, s_axis_tready = 0, c_drop_cnt = 0.
  - wr_ptr = wr_commit = rd_ptr = 0, pkt_cnt = 0, drop flag = 0.
  - Reset mid-packet discards all FIFO contents and any partial output; the next packet starts clean.
- Latency: input beat presented in an IDLE cycle N appears on m_axis at N+2. In DATA/CTRL, one cycle per beat.
- One bubble cycle (IDLE) between consecutive packets.
- Full throughput within a packet while m_axis_tready=1.
- A FIFO read and write in the same cycle: the freed slot is visible to the full check one cycle later.
- m_axis_tvalid=1 with m_axis_tready=0 holds all m_axis_* stable.

## Configuration
- PKT_MERGER_RR_EN:
  - Defined: on contention in IDLE, grant alternates, favouring the source not granted last. A last-grant register resets to DATA, so control wins the first tie.
  - Undefined: control has strict priority; data waits while ctrl_pend.

## Test plan
- Data-only: 3-beat packet on s_axis, m_axis_tready=1 -> identical 3 beats on m_axis; first beat 2 cycles after tvalid; c_drop_cnt=0.
- Control-only: 2-beat control packet with tdata[335:320]=16'hf2f1 -> emitted unchanged, beats contiguous, tlast on beat 2.
- Contention: control packet committed while 4-beat data packet waits in IDLE.
  - Strict: control first, then data.
  - RR_EN with a second tie: data then control.
- Overflow: depth 16, m_axis_tready=0, send a 10-beat then an 8-beat control packet.
  - Second packet dropped, c_drop_cnt=1, FIFO still holds exactly the first packet.
  - After releasing ready, only the 10 beats are output.
- Mid-stream data packet: control packet arriving during an 8-beat data packet is not interleaved; it is emitted after the data tlast plus one IDLE cycle.
- Back-pressure: toggle m_axis_tready every cycle during a 5-beat data packet -> no beat lost or duplicated; outputs stable while stalled.
- Reset mid-packet: assert aresetn=0 during beat 2 of a control packet -> all outputs 0; the next packet is passed correctly.

Source files
------------

// File: rtl/pkt_merger.sv
// Egress merge of the data-path stream and a staged control stream onto one registered AXI-Stream.
// Define PKT_MERGER_RR_EN for round-robin arbitration on contention (default: strict control).
`timescale 1ns/1ps
module pkt_merger #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_FIFO_DEPTH_LOG2    = 4
) (
    input  logic                                 clk,
    input  logic                                 aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic                                 s_axis_tvalid,
    input  logic                                 s_axis_tlast,
    output logic                                 s_axis_tready,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       c_s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     c_s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_s_axis_tuser,
    input  logic                                 c_s_axis_tvalid,
    input  logic                                 c_s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tvalid,
    output logic                                 m_axis_tlast,
    input  logic                                 m_axis_tready,
    output logic [31:0]                          c_drop_cnt
);

    localparam int DW    = C_S_AXIS_DATA_WIDTH;
    localparam int KW    = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW    = C_S_AXIS_TUSER_WIDTH;
    localparam int AW    = C_FIFO_DEPTH_LOG2;
    localparam int PW    = C_FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << C_FIFO_DEPTH_LOG2;
    localparam int BW    = DW + KW + UW + 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StData = 2'd1;
    localparam logic [1:0] StCtrl = 2'd2;

    logic [BW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_commit_q, rd_ptr_q, pkt_cnt_q;
    logic          drop_flag_q;
    logic [1:0]    state_q, state_d;

    logic          fifo_full, c_wr, c_commit, adv, s_fire, rd_en, rd_last, ctrl_pend;
    logic          grant_ctrl, grant_data;
    logic [DW-1:0] head_data;
    logic [KW-1:0] head_keep;
    logic [UW-1:0] head_user;
    logic          head_last;

    // Full check uses registered pointers only, so a same-cycle read frees space one cycle later.
    assign fifo_full = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    assign c_wr      = c_s_axis_tvalid & ~drop_flag_q & ~fifo_full;
    assign c_commit  = c_wr & c_s_axis_tlast;
    assign ctrl_pend = (pkt_cnt_q != '0);

    assign adv           = m_axis_tready | ~m_axis_tvalid;
    assign s_axis_tready = (state_q == StData) & adv;
    assign s_fire        = s_axis_tvalid & s_axis_tready;
    assign rd_en         = (state_q == StCtrl) & adv;

    assign {head_data, head_keep, head_user, head_last} = mem[rd_ptr_q[AW-1:0]];
    assign rd_last = rd_en & head_last;

`ifdef PKT_MERGER_RR_EN
    logic last_grant_ctrl_q;

    // On a tie, favour whichever source lost the previous tie.
    assign grant_ctrl = ctrl_pend & (~s_axis_tvalid | ~last_grant_ctrl_q);
    assign grant_data = s_axis_tvalid & ~grant_ctrl;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            last_grant_ctrl_q <= 1'b0;
        end else if (state_q == StIdle && ctrl_pend && s_axis_tvalid) begin
            last_grant_ctrl_q <= grant_ctrl;
        end
    end
`else
    assign grant_ctrl = ctrl_pend;
    assign grant_data = s_axis_tvalid & ~ctrl_pend;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_ctrl) begin
                    state_d = StCtrl;
                end else if (grant_data) begin
                    state_d = StData;
                end
            end
            StData:  if (s_fire && s_axis_tlast) state_d = StIdle;
            StCtrl:  if (rd_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (c_wr) begin
            mem[wr_ptr_q[AW-1:0]] <= {c_s_axis_tdata, c_s_axis_tkeep, c_s_axis_tuser,
                                      c_s_axis_tlast};
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            pkt_cnt_q   <= '0;
            drop_flag_q <= 1'b0;
            c_drop_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (c_s_axis_tvalid) begin
                if (drop_flag_q) begin
                    if (c_s_axis_tlast) drop_flag_q <= 1'b0;
                end else if (fifo_full) begin
                    wr_ptr_q    <= wr_commit_q;
                    drop_flag_q <= ~c_s_axis_tlast;
                    if (c_drop_cnt != 32'hFFFF_FFFF) c_drop_cnt <= c_drop_cnt + 32'd1;
                end else begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                    if (c_s_axis_tlast) wr_commit_q <= wr_ptr_q + PW'(1);
                end
            end
            if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (c_commit && !rd_last) begin
                pkt_cnt_q <= pkt_cnt_q + PW'(1);
            end else if (!c_commit && rd_last) begin
                pkt_cnt_q <= pkt_cnt_q - PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (adv) begin
            if (s_fire) begin
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tkeep  <= s_axis_tkeep;
                m_axis_tuser  <= s_axis_tuser;
                m_axis_tlast  <= s_axis_tlast;
                m_axis_tvalid <= 1'b1;
            end else if (rd_en) begin
                m_axis_tdata  <= head_data;
                m_axis_tkeep  <= head_keep;
                m_axis_tuser  <= head_user;
                m_axis_tlast  <= head_last;
                m_axis_tvalid <= 1'b1;
            end else begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pkt_merger.sv
// Directed bench for pkt_merger: cycle-accurate vector table plus multi-cycle sequences
// checked against an expected beat list built from the stimulus.
`timescale 1ns/1ps
module tb_pkt_merger;

    localparam int DW = 512;
    localparam int UW = 128;
    localparam int KW = DW / 8;

    logic          clk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] s_tdata, c_tdata, m_tdata;
    logic [KW-1:0] s_tkeep, c_tkeep, m_tkeep;
    logic [UW-1:0] s_tuser, c_tuser, m_tuser;
    logic          s_tvalid, s_tlast, s_tready;
    logic          c_tvalid, c_tlast;
    logic          m_tvalid, m_tlast, m_tready;
    logic [31:0]   drop_cnt;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [31:0] mon_tag[$];
    logic        mon_last[$];
    int          mon_cyc[$];
    logic [31:0] exp_tag[$];
    logic        exp_last[$];

    always #5 clk = ~clk;

    pkt_merger dut (
        .clk             (clk),
        .aresetn         (aresetn),
        .s_axis_tdata    (s_tdata),
        .s_axis_tkeep    (s_tkeep),
        .s_axis_tuser    (s_tuser),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tlast    (s_tlast),
        .s_axis_tready   (s_tready),
        .c_s_axis_tdata  (c_tdata),
        .c_s_axis_tkeep  (c_tkeep),
        .c_s_axis_tuser  (c_tuser),
        .c_s_axis_tvalid (c_tvalid),
        .c_s_axis_tlast  (c_tlast),
        .m_axis_tdata    (m_tdata),
        .m_axis_tkeep    (m_tkeep),
        .m_axis_tuser    (m_tuser),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tlast    (m_tlast),
        .m_axis_tready   (m_tready),
        .c_drop_cnt      (drop_cnt)
    );

    // A beat is fully determined by a 32-bit tag; tag[31:16] lands in tdata[335:320].
    function automatic logic [DW-1:0] mk_data(input logic [31:0] tag);
        logic [DW-1:0] d;
        d = '0;
        d[15:0]    = tag[15:0];
        d[335:320] = tag[31:16];
        d[511:480] = ~tag;
        return d;
    endfunction

    function automatic logic [KW-1:0] mk_keep(input logic [31:0] tag);
        return {48'hffff_ffff_ffff, ~tag[15:0]};
    endfunction

    function automatic logic [UW-1:0] mk_user(input logic [31:0] tag);
        return {tag, 64'h0123_4567_89ab_cdef, tag};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic chk_beat(input string name, input logic [31:0] tag, input logic last);
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== mk_data(tag) || m_tkeep !== mk_keep(tag) ||
            m_tuser !== mk_user(tag) || m_tlast !== last) begin
            n_err++;
            $display("FAIL %s: got valid=%b last=%b tag=%h expected valid=1 last=%b tag=%h",
                     name, m_tvalid, m_tlast, {m_tdata[335:320], m_tdata[15:0]}, last, tag);
        end
    endtask

    // Output monitor: records consumed beats, checks beat integrity and stall stability.
    initial begin : monitor
        logic          stall;
        logic [DW-1:0] snap_d;
        logic [KW-1:0] snap_k;
        logic [UW-1:0] snap_u;
        logic          snap_l;
        logic [31:0]   tag;
        stall = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            if (aresetn !== 1'b1) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    n_checks++;
                    if (m_tvalid !== 1'b1 || m_tdata !== snap_d || m_tkeep !== snap_k ||
                        m_tuser !== snap_u || m_tlast !== snap_l) begin
                        n_err++;
                        $display("FAIL stall_stable: got tag=%h valid=%b expected tag=%h valid=1",
                                 {m_tdata[335:320], m_tdata[15:0]}, m_tvalid,
                                 {snap_d[335:320], snap_d[15:0]});
                    end
                end
                stall  = m_tvalid && !m_tready;
                snap_d = m_tdata;
                snap_k = m_tkeep;
                snap_u = m_tuser;
                snap_l = m_tlast;
                if (m_tvalid && m_tready) begin
                    tag = {m_tdata[335:320], m_tdata[15:0]};
                    n_checks++;
                    if (m_tdata !== mk_data(tag) || m_tkeep !== mk_keep(tag) ||
                        m_tuser !== mk_user(tag)) begin
                        n_err++;
                        $display("FAIL beat_integrity: got keep=%h user=%h for tag=%h", m_tkeep,
                                 m_tuser, tag);
                    end
                    mon_tag.push_back(tag);
                    mon_last.push_back(m_tlast);
                    mon_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        mon_tag.delete();
        mon_last.delete();
        mon_cyc.delete();
        exp_tag.delete();
        exp_last.delete();
    endtask

    task automatic exp_pkt(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            exp_tag.push_back(base + 32'(i));
            exp_last.push_back(i == n - 1);
        end
    endtask

    task automatic send_ctrl(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            c_tvalid = 1'b1;
            c_tdata  = mk_data(base + 32'(i));
            c_tkeep  = mk_keep(base + 32'(i));
            c_tuser  = mk_user(base + 32'(i));
            c_tlast  = (i == n - 1);
        end
        @(negedge clk);
        c_tvalid = 1'b0;
        c_tlast  = 1'b0;
    endtask

    task automatic send_data(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            int w;
            @(negedge clk);
            s_tvalid = 1'b1;
            s_tdata  = mk_data(base + 32'(i));
            s_tkeep  = mk_keep(base + 32'(i));
            s_tuser  = mk_user(base + 32'(i));
            s_tlast  = (i == n - 1);
            w = 0;
            #4;
            while (!s_tready && w < 200) begin
                @(negedge clk);
                #4;
                w++;
            end
            chk("s_tready_handshake", 64'(s_tready), 64'd1);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic check_seq(input string name, input int budget);
        int k;
        k = 0;
        while (mon_tag.size() < exp_tag.size() && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (8) @(negedge clk);
        chk({name, "_count"}, 64'(mon_tag.size()), 64'(exp_tag.size()));
        for (int i = 0; i < exp_tag.size() && i < mon_tag.size(); i++) begin
            chk({name, "_tag"}, 64'(mon_tag[i]), 64'(exp_tag[i]));
            chk({name, "_last"}, 64'(mon_last[i]), 64'(exp_last[i]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        c_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
    endtask

    typedef struct packed {
        logic        sv;
        logic [31:0] stag;
        logic        sl;
        logic        cv;
        logic [31:0] ctag;
        logic        cl;
        logic        mr;
        logic        esr;
        logic        emv;
        logic [31:0] etag;
        logic        eml;
    } vec_t;

    vec_t vecs[12];

    initial begin : main
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0; s_tuser = '0;
        c_tvalid = 1'b0; c_tlast = 1'b0; c_tdata = '0; c_tkeep = '0; c_tuser = '0;
        m_tready = 1'b0;
        aresetn  = 1'b0;

        //           sv    stag          sl    cv    ctag          cl    mr    esr   emv   etag
        vecs[0]  = '{1'b1, 32'h0000_0a01, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0,
                     32'h0, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0a01, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1,
                     32'h0000_0a01, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0a02, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1,
                     32'h0000_0a02, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0a03, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1,
                     32'h0000_0a03, 1'b1};
        vecs[4]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0,
                     32'h0, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0,
                     32'h0, 1'b0};
        vecs[6]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hf2f1_0c01, 1'b0, 1'b1, 1'b0, 1'b0,
                     32'h0, 1'b0};
        vecs[7]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hf2f1_0c02, 1'b1, 1'b1, 1'b0, 1'b0,
                     32'h0, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0,
                     32'h0, 1'b0};
        vecs[9]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1,
                     32'hf2f1_0c01, 1'b0};
        vecs[10] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1,
                     32'hf2f1_0c02, 1'b1};
        vecs[11] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0,
                     32'h0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_m_tdata_any", 64'(|m_tdata), 64'd0);
        chk("rst_m_tkeep", 64'(m_tkeep), 64'd0);
        chk("rst_m_tuser_any", 64'(|m_tuser), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        aresetn = 1'b1;

        // Data-only then control-only, cycle by cycle
        for (int i = 0; i < 12; i++) begin
            s_tvalid = vecs[i].sv;
            s_tdata  = mk_data(vecs[i].stag);
            s_tkeep  = mk_keep(vecs[i].stag);
            s_tuser  = mk_user(vecs[i].stag);
            s_tlast  = vecs[i].sl;
            c_tvalid = vecs[i].cv;
            c_tdata  = mk_data(vecs[i].ctag);
            c_tkeep  = mk_keep(vecs[i].ctag);
            c_tuser  = mk_user(vecs[i].ctag);
            c_tlast  = vecs[i].cl;
            m_tready = vecs[i].mr;
            #1;
            chk("vec_s_tready", 64'(s_tready), 64'(vecs[i].esr));
            @(posedge clk);
            #1;
            if (vecs[i].emv) chk_beat("vec_m_beat", vecs[i].etag, vecs[i].eml);
            else chk("vec_m_tvalid", 64'(m_tvalid), 64'd0);
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        c_tvalid = 1'b0;
        chk("vec_drop_cnt", 64'(drop_cnt), 64'd0);

        // Contention: control commits while data is waiting in IDLE, twice
        do_reset();
        m_tready = 1'b1;
        clear_mon();
        for (int t = 0; t < 2; t++) begin
            logic [31:0] cb, db;
            cb = 32'hc100_0000 + 32'(t) * 32'h0100_0000;
            db = 32'hd100_0000 + 32'(t) * 32'h0100_0000;
            fork
                send_ctrl(2, cb);
                begin
                    repeat (2) @(negedge clk);
                    send_data(4, db);
                end
            join
`ifdef PKT_MERGER_RR_EN
            if (t == 0) begin
                exp_pkt(2, cb);
                exp_pkt(4, db);
            end else begin
                exp_pkt(4, db);
                exp_pkt(2, cb);
            end
`else
            exp_pkt(2, cb);
            exp_pkt(4, db);
`endif
            repeat (10) @(negedge clk);
        end
        check_seq("contention", 60);

        // Overflow: 10-beat packet fits, following 8-beat packet cannot
        do_reset();
        m_tready = 1'b0;
        clear_mon();
        send_ctrl(10, 32'hc300_0000);
        send_ctrl(8, 32'hc400_0000);
        repeat (4) @(negedge clk);
        chk("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
        chk_beat("ovf_held_beat", 32'hc300_0000, 1'b0);
        m_tready = 1'b1;
        exp_pkt(10, 32'hc300_0000);
        check_seq("overflow", 60);

        // Reset during beat 2 of a control packet, with a data beat held on the output
        m_tready = 1'b0;
        clear_mon();
        @(negedge clk);
        s_tvalid = 1'b1; s_tdata = mk_data(32'hd500_0000); s_tkeep = mk_keep(32'hd500_0000);
        s_tuser = mk_user(32'hd500_0000); s_tlast = 1'b0;
        @(negedge clk);
        c_tvalid = 1'b1; c_tdata = mk_data(32'hc500_0000); c_tkeep = mk_keep(32'hc500_0000);
        c_tuser = mk_user(32'hc500_0000); c_tlast = 1'b0;
        @(negedge clk);
        chk_beat("rst_mid_pre", 32'hd500_0000, 1'b0);
        c_tdata = mk_data(32'hc500_0001); c_tkeep = mk_keep(32'hc500_0001);
        c_tuser = mk_user(32'hc500_0001);
        aresetn = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_mid_m_tdata_any", 64'(|m_tdata), 64'd0);
        chk("rst_mid_m_tkeep", 64'(m_tkeep), 64'd0);
        chk("rst_mid_m_tuser_any", 64'(|m_tuser), 64'd0);
        chk("rst_mid_s_tready", 64'(s_tready), 64'd0);
        chk("rst_mid_drop_cnt", 64'(drop_cnt), 64'd0);
        @(negedge clk);
        aresetn  = 1'b1;
        s_tvalid = 1'b0;
        c_tvalid = 1'b0;
        m_tready = 1'b1;
        send_ctrl(2, 32'hc600_0000);
        exp_pkt(2, 32'hc600_0000);
        check_seq("after_reset", 40);

        // Control arriving mid data packet waits for data tlast plus one IDLE cycle
        clear_mon();
        fork
            send_data(8, 32'hd700_0000);
            begin
                repeat (3) @(negedge clk);
                send_ctrl(2, 32'hc700_0000);
            end
        join
        exp_pkt(8, 32'hd700_0000);
        exp_pkt(2, 32'hc700_0000);
        check_seq("midstream", 60);
        if (mon_cyc.size() == 10) begin
            for (int i = 0; i < 7; i++) chk("mid_data_gap", 64'(mon_cyc[i+1] - mon_cyc[i]), 64'd1);
            chk("mid_ctrl_gap", 64'(mon_cyc[8] - mon_cyc[7]), 64'd2);
            chk("mid_ctrl_contig", 64'(mon_cyc[9] - mon_cyc[8]), 64'd1);
        end

        // Back-pressure: m_tready toggles every cycle across a 5-beat data packet
        clear_mon();
        fork
            send_data(5, 32'hd800_0000);
            begin
                for (int i = 0; i < 14; i++) begin
                    @(negedge clk);
                    m_tready = i[0];
                end
                m_tready = 1'b1;
            end
        join
        exp_pkt(5, 32'hd800_0000);
        check_seq("backpressure", 40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
